// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Hardwired control unit for the Mini-SRC datapath. It steps
//               through instruction fetch (T0-T2) and the three-operand ALU
//               execute sequence (T3-T5), waits in T1 for memory, and stops
//               in HALT on a halt opcode or an unsupported opcode.
// Ports       : clock      - rising-edge system clock
//               clear      - asynchronous active-low reset
//               ir         - instruction register contents from the datapath
//               mem_ready  - Mdatain valid; sampled on the edge leaving T1
//               PCout, Zlowout, MDRout            - bus drive enables
//               MARin, PCin, MDRin, IRin, Yin, Zlowin - register load enables
//               IncPC, Read                       - PC increment, memory read
//               Gra, Grb, Grc, Rin, Rout          - general register selects
//               alu_op     - ALU opcode to the datapath
//               run        - high while sequencing (T0-T5)
//               illegal    - sticky flag for an unsupported opcode
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
  parameter logic [4:0] HALT_OP = 5'b11011,
  parameter int         OP_W    = 5
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zlowin,
  output logic            IncPC,
  output logic            Read,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic [OP_W-1:0] alu_op,
  output logic            run,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  typedef struct packed {
    logic PCout;
    logic Zlowout;
    logic MDRout;
    logic MARin;
    logic PCin;
    logic MDRin;
    logic IRin;
    logic Yin;
    logic Zlowin;
    logic IncPC;
    logic Read;
    logic Gra;
    logic Grb;
    logic Grc;
    logic Rin;
    logic Rout;
    logic run;
  } ctrl_t;

  state_t             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic               illegal_q, illegal_d;

  logic [4:0]         op;
  logic [OP_W-1:0]    op_xlate;
  logic               op_valid;

  // ra/rb/rc are decoded inside the datapath through Gra/Grb/Grc; only the
  // opcode field is needed here.
  logic               unused_ir_fields;
  assign unused_ir_fields = ^ir[26:0];

  assign op = ir[31:27];

  // Instruction opcode to datapath ALU opcode.
  always_comb begin
    op_valid = 1'b1;
    op_xlate = '0;
    case (op)
      5'b00011: op_xlate = OP_W'(5'b00011); // add
      5'b00100: op_xlate = OP_W'(5'b00100); // sub
      5'b00101: op_xlate = OP_W'(5'b01010); // and
      5'b00110: op_xlate = OP_W'(5'b01011); // or
      5'b00111: op_xlate = OP_W'(5'b00101); // shr
      5'b01000: op_xlate = OP_W'(5'b01001); // shra
      5'b01001: op_xlate = OP_W'(5'b00110); // shl
      5'b01010: op_xlate = OP_W'(5'b00111); // ror
      5'b01011: op_xlate = OP_W'(5'b01000); // rol
      default:  op_valid = 1'b0;
    endcase
  end

  // Next state and sticky illegal flag.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (op == HALT_OP) begin
          state_d = S_HALT;
        end else if (!op_valid) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_T4;
        end
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being
  // entered; each strobe is then valid for the whole of its state.
  always_comb begin
    ctrl_d   = '0;
    alu_op_d = alu_op_q;
    case (state_d)
      S_T0: begin
        ctrl_d.PCout  = 1'b1;
        ctrl_d.MARin  = 1'b1;
        ctrl_d.IncPC  = 1'b1;
        ctrl_d.Zlowin = 1'b1;
      end
      S_T1: begin
        ctrl_d.Zlowout = 1'b1;
        ctrl_d.PCin    = 1'b1;
        ctrl_d.Read    = 1'b1;
        ctrl_d.MDRin   = 1'b1;
      end
      S_T2: begin
        ctrl_d.MDRout = 1'b1;
        ctrl_d.IRin   = 1'b1;
      end
      S_T3: begin
        ctrl_d.Grb  = 1'b1;
        ctrl_d.Rout = 1'b1;
        ctrl_d.Yin  = 1'b1;
      end
      S_T4: begin
        ctrl_d.Grc    = 1'b1;
        ctrl_d.Rout   = 1'b1;
        ctrl_d.Zlowin = 1'b1;
        alu_op_d      = op_xlate;
      end
      S_T5: begin
        ctrl_d.Zlowout = 1'b1;
        ctrl_d.Gra     = 1'b1;
        ctrl_d.Rin     = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
    ctrl_d.run = (state_d != S_RST) && (state_d != S_HALT);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_RST;
      ctrl_q    <= '0;
      alu_op_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      alu_op_q  <= alu_op_d;
      illegal_q <= illegal_d;
    end
  end

  assign PCout   = ctrl_q.PCout;
  assign Zlowout = ctrl_q.Zlowout;
  assign MDRout  = ctrl_q.MDRout;
  assign MARin   = ctrl_q.MARin;
  assign PCin    = ctrl_q.PCin;
  assign MDRin   = ctrl_q.MDRin;
  assign IRin    = ctrl_q.IRin;
  assign Yin     = ctrl_q.Yin;
  assign Zlowin  = ctrl_q.Zlowin;
  assign IncPC   = ctrl_q.IncPC;
  assign Read    = ctrl_q.Read;
  assign Gra     = ctrl_q.Gra;
  assign Grb     = ctrl_q.Grb;
  assign Grc     = ctrl_q.Grc;
  assign Rin     = ctrl_q.Rin;
  assign Rout    = ctrl_q.Rout;
  assign run     = ctrl_q.run;
  assign alu_op  = alu_op_q;
  assign illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer. Stimulus pushes the
//               expected output word for every cycle into a queue; a monitor
//               pops and compares it on each falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        mem_ready;
  logic        PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zlowin;
  logic        IncPC, Read, Gra, Grb, Grc, Rin, Rout, run, illegal;
  logic [4:0]  alu_op;

  control_sequencer #(.HALT_OP(5'b11011), .OP_W(5)) dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin),
    .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .run(run), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // Output word layout: strobes high to low, then run, illegal, alu_op.
  typedef logic [22:0] vec_t;
  localparam int B_PCOUT = 22, B_ZLOWOUT = 21, B_MDROUT = 20, B_MARIN = 19;
  localparam int B_PCIN = 18, B_MDRIN = 17, B_IRIN = 16, B_YIN = 15;
  localparam int B_ZLOWIN = 14, B_INCPC = 13, B_READ = 12, B_GRA = 11;
  localparam int B_GRB = 10, B_GRC = 9, B_RIN = 8, B_ROUT = 7, B_RUN = 6;
  localparam int B_ILL = 5;

  // Instruction phases as seen from outside (IDLE covers reset and halt).
  localparam int P_IDLE = 0, P_T0 = 1, P_T1 = 2, P_T2 = 3;
  localparam int P_T3 = 4, P_T4 = 5, P_T5 = 6;

  localparam logic [4:0] OP_HALT = 5'b11011;

  vec_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [4:0] m_alu;
  logic       m_ill;
  vec_t       mon_got, mon_exp;

  function automatic vec_t sample_outputs();
    return {PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zlowin,
            IncPC, Read, Gra, Grb, Grc, Rin, Rout, run, illegal, alu_op};
  endfunction

  // {valid, alu code} for an instruction opcode.
  function automatic logic [5:0] xlate(input logic [4:0] op);
    case (op)
      5'b00011: return {1'b1, 5'b00011};
      5'b00100: return {1'b1, 5'b00100};
      5'b00101: return {1'b1, 5'b01010};
      5'b00110: return {1'b1, 5'b01011};
      5'b00111: return {1'b1, 5'b00101};
      5'b01000: return {1'b1, 5'b01001};
      5'b01001: return {1'b1, 5'b00110};
      5'b01010: return {1'b1, 5'b00111};
      5'b01011: return {1'b1, 5'b01000};
      default:  return 6'b0;
    endcase
  endfunction

  function automatic vec_t phase_vec(input int ph, input logic [4:0] alu, input logic ill);
    vec_t v;
    v = '0;
    case (ph)
      P_T0: begin v[B_PCOUT] = 1; v[B_MARIN] = 1; v[B_INCPC] = 1; v[B_ZLOWIN] = 1; end
      P_T1: begin v[B_ZLOWOUT] = 1; v[B_PCIN] = 1; v[B_READ] = 1; v[B_MDRIN] = 1; end
      P_T2: begin v[B_MDROUT] = 1; v[B_IRIN] = 1; end
      P_T3: begin v[B_GRB] = 1; v[B_ROUT] = 1; v[B_YIN] = 1; end
      P_T4: begin v[B_GRC] = 1; v[B_ROUT] = 1; v[B_ZLOWIN] = 1; end
      P_T5: begin v[B_ZLOWOUT] = 1; v[B_GRA] = 1; v[B_RIN] = 1; end
      default: v = '0;
    endcase
    v[B_RUN] = (ph != P_IDLE);
    v[B_ILL] = ill;
    v[4:0]   = alu;
    return v;
  endfunction

  // Monitor: every cycle that has an expectation queued is compared.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = sample_outputs();
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, mon_got, mon_exp);
      end
    end
  end

  // One clock cycle: after the edge, set mem_ready for the edge that ends
  // this cycle and queue the outputs expected during it.
  task automatic cyc(input int ph, input logic mr);
    @(posedge clock);
    #1;
    mem_ready = mr;
    exp_q.push_back(phase_vec(ph, m_alu, m_ill));
  endtask

  task automatic do_reset();
    m_alu = '0;
    m_ill = 1'b0;
    cyc(P_IDLE, 1'b1);
    clear = 1'b0;
    cyc(P_IDLE, 1'b1);
    clear = 1'b1;
  endtask

  task automatic do_instr(input logic [31:0] instr, input int waits,
                          input bit abort_t4, input int halt_cycles);
    logic [5:0] x;
    vec_t       got;
    x = xlate(instr[31:27]);
    cyc(P_T0, 1'($urandom));
    ir = $urandom;                       // junk before the fetch completes
    for (int i = 0; i < waits; i++) cyc(P_T1, 1'b0);
    cyc(P_T1, 1'b1);
    cyc(P_T2, 1'($urandom));
    ir = instr;                          // value the datapath loads in T2
    cyc(P_T3, 1'($urandom));
    if (x[5]) begin
      m_alu = x[4:0];
      cyc(P_T4, 1'($urandom));
      if (abort_t4) begin
        @(negedge clock);
        #2;
        clear = 1'b0;
        #1;
        got = sample_outputs();
        checks++;
        if (got !== '0) begin
          errors++;
          $display("FAIL async_clear_in_t4 got=%h expected=%h", got, vec_t'(0));
        end
        m_alu = '0;
        m_ill = 1'b0;
        cyc(P_IDLE, 1'b1);
        clear = 1'b1;
      end else begin
        cyc(P_T5, 1'($urandom));
      end
    end else begin
      if (instr[31:27] != OP_HALT) m_ill = 1'b1;
      for (int i = 0; i < halt_cycles; i++) cyc(P_IDLE, 1'($urandom));
    end
  endtask

  function automatic logic [4:0] rand_valid_op();
    logic [4:0] ops [9];
    ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011};
    return ops[$urandom_range(0, 8)];
  endfunction

  initial begin
    logic [4:0] op;
    clear     = 1'b1;
    mem_ready = 1'b1;
    ir        = '0;
    m_alu     = '0;
    m_ill     = 1'b0;
    #1 clear  = 1'b0;
    cyc(P_IDLE, 1'b1);
    cyc(P_IDLE, 1'b1);
    clear = 1'b1;

    // and R1,R2,R3 with memory ready immediately
    do_instr(32'h28918000, 0, 0, 0);
    // three memory wait cycles in T1
    do_instr({5'b00100, 27'($urandom)}, 3, 0, 0);
    // back-to-back add then shl
    do_instr({5'b00011, 27'($urandom)}, 0, 0, 0);
    do_instr({5'b01001, 27'($urandom)}, 0, 0, 0);
    // clear asserted between edges in T4, then restart
    do_instr({5'b00110, 27'($urandom)}, 1, 1, 0);
    do_instr({5'b01010, 27'($urandom)}, 0, 0, 0);

    // randomized valid instructions with random memory waits
    for (int n = 0; n < 40; n++)
      do_instr({rand_valid_op(), 27'($urandom)}, $urandom_range(0, 3), 0, 0);

    // halt opcode: no illegal, quiet for 20 cycles
    do_instr({OP_HALT, 27'($urandom)}, 0, 0, 20);
    do_reset();
    // unsupported opcode: illegal held until clear
    do_instr({5'b11111, 27'($urandom)}, 2, 0, 10);
    do_reset();

    // fully random opcodes, including unsupported ones
    for (int n = 0; n < 12; n++) begin
      op = 5'($urandom);
      do_instr({op, 27'($urandom)}, $urandom_range(0, 2), 0, 3);
      if (!xlate(op)[5]) do_reset();
    end
    do_instr({rand_valid_op(), 27'($urandom)}, 0, 0, 0);

    repeat (4) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
